gshare_direction_predictor: RTL and testbench

//  Gshare branch-direction predictor feeding the BTB's taken decision in IF.

---
 rtl/gshare_if.sv | 31 +++
 rtl/gshare_direction_predictor.sv | 108 ++++++++++
 tb/tb_gshare_direction_predictor.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_if.sv
// Pipeline-side signal bundle for the gshare direction predictor.
// The pipeline (master) supplies the fetch PC and EX resolution results.
// The predictor (slave) returns the prediction, history snapshot and perf counts.
interface gshare_if #(
   parameter int PHT_BIT = 5
);
   logic [31:0]        current_pc;
   logic               pred_taken;
   logic [PHT_BIT-1:0] pred_ghr;
   logic [31:0]        ID_EX_pc;
   logic [PHT_BIT-1:0] ID_EX_ghr;
   logic               ID_EX_is_branch;
   logic               ID_EX_pred_taken;
   logic               EX_alu_bcond;
   logic               EX_stall;
   logic               init_busy;
   logic [31:0]        branch_cnt;
   logic [31:0]        mispredict_cnt;

   modport master (
      output current_pc, ID_EX_pc, ID_EX_ghr, ID_EX_is_branch,
             ID_EX_pred_taken, EX_alu_bcond, EX_stall,
      input  pred_taken, pred_ghr, init_busy, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  current_pc, ID_EX_pc, ID_EX_ghr, ID_EX_is_branch,
             ID_EX_pred_taken, EX_alu_bcond, EX_stall,
      output pred_taken, pred_ghr, init_busy, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/gshare_direction_predictor.sv
// Gshare branch-direction predictor.
// PHT of 2-bit saturating counters indexed by PC[PHT_BIT+1:2] ^ GHR.
// After reset, an init walk sets every entry to weakly not-taken before predicting.
// Training and the global history are updated only from non-stalled EX resolution.
module gshare_direction_predictor #(
   parameter int PHT_BIT = 5
) (
   input logic    clk,
   input logic    reset,
   gshare_if.slave bus
);
   localparam int ENTRIES = 1 << PHT_BIT;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t             state;
   logic [PHT_BIT-1:0] init_ptr;
   logic               init_busy_q;
   logic [PHT_BIT-1:0] ghr;
   logic [31:0]        branch_cnt_q;
   logic [31:0]        mispredict_cnt_q;
   logic [1:0]         pht [ENTRIES];

   logic [PHT_BIT-1:0] idx_p;
   logic [PHT_BIT-1:0] idx_u;
   logic               train;
   logic [1:0]         ctr_next;

   // PC bits outside the index field are intentionally ignored.
   wire unused_pc_bits = ^{bus.current_pc[31:PHT_BIT+2], bus.current_pc[1:0],
                           bus.ID_EX_pc[31:PHT_BIT+2], bus.ID_EX_pc[1:0]};

   assign idx_p = bus.current_pc[PHT_BIT+1:2] ^ ghr;
   assign idx_u = bus.ID_EX_pc[PHT_BIT+1:2] ^ bus.ID_EX_ghr;
   assign train = (state == ST_RUN) && bus.ID_EX_is_branch && !bus.EX_stall;

   // Combinational read returns the pre-update counter on a same-index collision.
   assign bus.pred_taken     = (state == ST_RUN) && pht[idx_p][1];
   assign bus.pred_ghr       = ghr;
   assign bus.init_busy      = init_busy_q;
   assign bus.branch_cnt     = branch_cnt_q;
   assign bus.mispredict_cnt = mispredict_cnt_q;

   // Saturating counter step for the entry being trained.
   always_comb begin
      // NOTE: default first so every path assigns ctr_next and no latch is inferred.
      ctr_next = pht[idx_u];
      if (bus.EX_alu_bcond && (pht[idx_u] != 2'b11)) begin
         ctr_next = pht[idx_u] + 2'b01;
      end else if (!bus.EX_alu_bcond && (pht[idx_u] != 2'b00)) begin
         ctr_next = pht[idx_u] - 2'b01;
      end
   end

   // Init-walk FSM: INIT sweeps every entry once, then RUN until the next reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: non-blocking assignments for all flop state so every block sees pre-edge values.
         state       <= ST_INIT;
         init_ptr    <= '0;
         init_busy_q <= 1'b1;
      end else begin
         case (state)
            ST_INIT: begin
               init_ptr <= init_ptr + 1'b1;
               if (init_ptr == PHT_BIT'(ENTRIES - 1)) begin
                  state       <= ST_RUN;
                  init_busy_q <= 1'b0;
               end
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   // PHT writes: init fill, or one trained entry per resolved branch.
   // NOTE: the array has no reset; the init walk gives it a known value before first use.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         pht[init_ptr] <= 2'b01;
      end else if (train) begin
         pht[idx_u] <= ctr_next;
      end
   end

   // Non-speculative history and saturating perf counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr              <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else if (train) begin
         ghr <= {ghr[PHT_BIT-2:0], bus.EX_alu_bcond};
         if (branch_cnt_q != 32'hFFFF_FFFF) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
         end
         if ((bus.ID_EX_pred_taken != bus.EX_alu_bcond) &&
             (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_gshare_direction_predictor.sv
// Self-checking bench for gshare_direction_predictor (PHT_BIT = 5).
// A behavioural model (array of integer counters, integer history, cycle countdown
// for the init walk) is compared against the DUT on every falling edge, and a set
// of hand-computed literal expectations pins the model for the directed scenarios.
module tb_gshare_direction_predictor;
   localparam int PHT_BIT = 5;
   localparam int ENTRIES = 1 << PHT_BIT;

   logic clk;
   logic reset;

   gshare_if #(.PHT_BIT(PHT_BIT)) bus ();

   gshare_direction_predictor #(.PHT_BIT(PHT_BIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // Behavioural model state.
   int     m_pht [ENTRIES];
   int     m_ghr       = 0;
   int     m_init_left = ENTRIES;
   longint m_bc        = 0;
   longint m_mc        = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int pc_idx(input logic [31:0] pc);
      return int'(pc[PHT_BIT+1:2]);
   endfunction

   function automatic logic model_pred(input logic [31:0] pc);
      if (m_init_left != 0) return 1'b0;
      return m_pht[pc_idx(pc) ^ m_ghr] >= 2;
   endfunction

   // Model: reset, init countdown, then training from unstalled EX branches.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_init_left = ENTRIES;
         m_ghr       = 0;
         m_bc        = 0;
         m_mc        = 0;
      end else if (m_init_left > 0) begin
         m_pht[ENTRIES - m_init_left] = 1;
         m_init_left--;
      end else if (bus.ID_EX_is_branch && !bus.EX_stall) begin
         int idx;
         idx = pc_idx(bus.ID_EX_pc) ^ int'(bus.ID_EX_ghr);
         if (bus.EX_alu_bcond) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
         else                  m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
         m_ghr = ((m_ghr * 2) + int'(bus.EX_alu_bcond)) % ENTRIES;
         if (m_bc < 64'hFFFF_FFFF) m_bc++;
         if ((bus.ID_EX_pred_taken != bus.EX_alu_bcond) && (m_mc < 64'hFFFF_FFFF)) m_mc++;
      end
   end

   // Compare process: all outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("pred_taken",     64'(bus.pred_taken),     64'(model_pred(bus.current_pc)));
         check("pred_ghr",       64'(bus.pred_ghr),       64'(m_ghr));
         check("init_busy",      64'(bus.init_busy),      64'(m_init_left != 0));
         check("branch_cnt",     64'(bus.branch_cnt),     64'(m_bc));
         check("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(m_mc));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Counts falling edges with init_busy high, bounded so a stuck walk still ends.
   task automatic count_init(output int cnt);
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!bus.init_busy) break;
         cnt++;
      end
      step();
   endtask

   task automatic do_reset();
      int cnt;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      count_init(cnt);
      check("init_cycles", 64'(cnt), 64'd32);
   endtask

   // One resolved branch in EX, carrying the history and prediction it was fetched with.
   task automatic resolve(input logic [31:0] pc, input logic taken);
      bus.ID_EX_pc         = pc;
      bus.ID_EX_ghr        = PHT_BIT'(m_ghr);
      bus.ID_EX_pred_taken = model_pred(pc);
      bus.EX_alu_bcond     = taken;
      bus.ID_EX_is_branch  = 1'b1;
      bus.EX_stall         = 1'b0;
      step();
      bus.ID_EX_is_branch  = 1'b0;
   endtask

   initial begin
      int     cnt;
      longint mc_snap;
      logic   outcome [7];

      reset                = 1'b0;
      bus.current_pc       = '0;
      bus.ID_EX_pc         = '0;
      bus.ID_EX_ghr        = '0;
      bus.ID_EX_is_branch  = 1'b0;
      bus.ID_EX_pred_taken = 1'b0;
      bus.EX_alu_bcond     = 1'b0;
      bus.EX_stall         = 1'b0;
      step();
      cmp_en = 1'b1;

      // Reset release: 32-cycle init walk, no prediction, zeroed counters.
      do_reset();
      check("post_init_branch_cnt", 64'(bus.branch_cnt), 64'd0);
      check("post_init_mispredict", 64'(bus.mispredict_cnt), 64'd0);

      // Repeated taken branch at 0x40 with GHR 0 in flight: entry 0x10 goes 01->10->11->11.
      bus.current_pc = 32'h40;
      for (int i = 0; i < 3; i++) begin
         bus.ID_EX_pc         = 32'h40;
         bus.ID_EX_ghr        = '0;
         bus.ID_EX_pred_taken = (m_pht[16] >= 2);
         bus.EX_alu_bcond     = 1'b1;
         bus.ID_EX_is_branch  = 1'b1;
         step();
      end
      bus.ID_EX_is_branch = 1'b0;
      check("t2_ghr",        64'(bus.pred_ghr), 64'b00111);
      check("t2_branch_cnt", 64'(bus.branch_cnt), 64'd3);
      check("t2_mispredict", 64'(bus.mispredict_cnt), 64'd1);
      bus.current_pc = 32'h5C;           // index 0x17 ^ 0x07 = 0x10, counter now 11
      #1;
      check("t2_entry10_taken", 64'(bus.pred_taken), 64'd1);
      step();

      // Same-index read and write: old value this cycle, new value next cycle.
      do_reset();
      bus.current_pc       = 32'h40;
      bus.ID_EX_pc         = 32'h40;
      bus.ID_EX_ghr        = '0;
      bus.ID_EX_pred_taken = 1'b0;
      bus.EX_alu_bcond     = 1'b1;
      bus.ID_EX_is_branch  = 1'b1;
      @(negedge clk);
      check("t5_pred_before", 64'(bus.pred_taken), 64'd0);
      step();
      bus.ID_EX_is_branch = 1'b0;
      bus.current_pc      = 32'h44;      // index 0x11 ^ GHR 0x01 = 0x10
      @(negedge clk);
      check("t5_pred_after", 64'(bus.pred_taken), 64'd1);
      step();

      // Three stalled cycles then one unstalled: exactly one update.
      bus.ID_EX_pc         = 32'h80;
      bus.ID_EX_ghr        = PHT_BIT'(m_ghr);
      bus.ID_EX_pred_taken = model_pred(32'h80);
      bus.EX_alu_bcond     = 1'b1;
      bus.ID_EX_is_branch  = 1'b1;
      bus.EX_stall         = 1'b1;
      step();
      step();
      step();
      check("t4_stall_cnt_held", 64'(bus.branch_cnt), 64'd1);
      check("t4_stall_ghr_held", 64'(bus.pred_ghr), 64'b00001);
      bus.EX_stall = 1'b0;
      step();
      bus.ID_EX_is_branch = 1'b0;
      check("t4_branch_cnt", 64'(bus.branch_cnt), 64'd2);
      check("t4_ghr",        64'(bus.pred_ghr), 64'b00011);

      // Alternating T/N at PC 0: after warm-up the mispredict count stops moving.
      do_reset();
      bus.current_pc = 32'h0;
      for (int i = 0; i < 40; i++) resolve(32'h0, logic'(i % 2 == 0));
      mc_snap = m_mc;
      for (int i = 40; i < 60; i++) resolve(32'h0, logic'(i % 2 == 0));
      check("t3_no_new_mispredicts", 64'(bus.mispredict_cnt), 64'(mc_snap));
      check("t3_branch_cnt", 64'(bus.branch_cnt), 64'd60);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bus.current_pc       = $urandom;
         bus.ID_EX_pc         = $urandom;
         bus.ID_EX_ghr        = PHT_BIT'($urandom);
         bus.ID_EX_pred_taken = 1'($urandom);
         bus.EX_alu_bcond     = 1'($urandom);
         bus.ID_EX_is_branch  = ($urandom_range(0, 3) != 0);
         bus.EX_stall         = ($urandom_range(0, 4) == 0);
         step();
      end
      bus.ID_EX_is_branch = 1'b0;
      bus.EX_stall        = 1'b0;

      // Reset pulse mid-RUN with GHR 10110 and seven branches counted.
      do_reset();
      outcome = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) resolve(32'h100, outcome[i]);
      check("t6_ghr_before",   64'(bus.pred_ghr), 64'b10110);
      check("t6_branch_before", 64'(bus.branch_cnt), 64'd7);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("t6_ghr_async",    64'(bus.pred_ghr), 64'd0);
      check("t6_branch_async", 64'(bus.branch_cnt), 64'd0);
      check("t6_busy_async",   64'(bus.init_busy), 64'd1);
      step();
      reset                = 1'b1;
      bus.ID_EX_pc         = 32'h100;
      bus.ID_EX_ghr        = '0;
      bus.ID_EX_pred_taken = 1'b0;
      bus.EX_alu_bcond     = 1'b1;
      bus.ID_EX_is_branch  = 1'b1;
      step();
      bus.ID_EX_is_branch  = 1'b0;
      count_init(cnt);
      check("t6_init_cycles",   64'(cnt + 1), 64'd32);
      check("t6_branch_in_init", 64'(bus.branch_cnt), 64'd0);
      check("t6_ghr_in_init",    64'(bus.pred_ghr), 64'd0);
      step();

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
